// File: rtl/gshare_btb_predictor_if.sv
// Interface between the IF/EX stages and the gshare/BTB branch predictor.
// The master side drives the fetch PC and resolved-branch updates; the slave
// side (the predictor) returns the next fetch PC, status and perf counters.
interface gshare_btb_predictor_if #(
  parameter int PERF_WIDTH = 32
);
  logic [31:0]           current_pc;
  logic [31:0]           predicted_pc;
  logic                  predict_taken;
  logic                  ready;
  logic                  update_valid;
  logic [31:0]           update_pc;
  logic                  update_taken;
  logic [31:0]           update_target;
  logic                  update_mispredict;
  logic [PERF_WIDTH-1:0] perf_branches;
  logic [PERF_WIDTH-1:0] perf_mispredicts;

  modport master (
    output current_pc,
    output update_valid,
    output update_pc,
    output update_taken,
    output update_target,
    output update_mispredict,
    input  predicted_pc,
    input  predict_taken,
    input  ready,
    input  perf_branches,
    input  perf_mispredicts
  );

  modport slave (
    input  current_pc,
    input  update_valid,
    input  update_pc,
    input  update_taken,
    input  update_target,
    input  update_mispredict,
    output predicted_pc,
    output predict_taken,
    output ready,
    output perf_branches,
    output perf_mispredicts
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Gshare (or bimodal) direction predictor with a tagged direct-mapped BTB.
// Prediction is combinational from current_pc; training happens on the clock
// edge when EX presents a resolved branch. After reset a small FSM walks the
// tables one entry per cycle, clearing them, before the predictor goes live.
module gshare_btb_predictor #(
  parameter int PHT_INDEX_BITS = 6,
  parameter int HIST_BITS      = 6,
  parameter int BTB_INDEX_BITS = 5,
  parameter int COUNTER_BITS   = 2,
  parameter bit MODE           = 1'b1,
  parameter int PERF_WIDTH     = 32
) (
  input logic                   clk,
  input logic                   rst,
  gshare_btb_predictor_if.slave bus
);

  localparam int PHT_ENTRIES = 2 ** PHT_INDEX_BITS;
  localparam int BTB_ENTRIES = 2 ** BTB_INDEX_BITS;
  localparam int INIT_BITS   = (PHT_INDEX_BITS > BTB_INDEX_BITS) ? PHT_INDEX_BITS : BTB_INDEX_BITS;
  localparam int TAG_BITS    = 30 - BTB_INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] WEAK_NT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [INIT_BITS-1:0]      init_idx;
  logic                      init_last;
  logic                      run;
  logic                      upd_fire;

  logic [COUNTER_BITS-1:0]   pht        [PHT_ENTRIES];
  logic                      btb_valid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]               btb_target [BTB_ENTRIES];

  logic [HIST_BITS-1:0]      ghr;
  logic [PERF_WIDTH-1:0]     perf_branches_q;
  logic [PERF_WIDTH-1:0]     perf_mispredicts_q;

  logic [PHT_INDEX_BITS-1:0] pred_pht_idx;
  logic [BTB_INDEX_BITS-1:0] pred_btb_idx;
  logic [TAG_BITS-1:0]       pred_tag;
  logic [COUNTER_BITS-1:0]   pred_ctr;
  logic                      pred_hit;

  logic [PHT_INDEX_BITS-1:0] upd_pht_idx;
  logic [BTB_INDEX_BITS-1:0] upd_btb_idx;
  logic [TAG_BITS-1:0]       upd_tag;
  logic [COUNTER_BITS-1:0]   upd_ctr_old;
  logic [COUNTER_BITS-1:0]   upd_ctr_new;

  logic                      unused_pc_bits;

  // PHT index: word-aligned PC bits, optionally hashed with zero-extended history
  function automatic logic [PHT_INDEX_BITS-1:0] pht_index(input logic [31:0] pc,
                                                          input logic [HIST_BITS-1:0] hist);
    logic [PHT_INDEX_BITS-1:0] hist_ext;
    hist_ext = '0;
    hist_ext[HIST_BITS-1:0] = hist;
    return MODE ? (pc[PHT_INDEX_BITS+1:2] ^ hist_ext) : pc[PHT_INDEX_BITS+1:2];
  endfunction

  assign run       = (state == ST_RUN);
  assign upd_fire  = run && bus.update_valid;
  assign init_last = (init_idx == '1);

  // State register; reset forces the table walk to restart immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  // Leave INIT once the last table index has been cleared
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_last) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Walk pointer for table initialisation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  init_idx <= '0;
    else if (state == ST_INIT) init_idx <= init_idx + INIT_BITS'(1);
  end

  assign pred_pht_idx = pht_index(bus.current_pc, ghr);
  assign pred_btb_idx = bus.current_pc[BTB_INDEX_BITS+1:2];
  assign pred_tag     = bus.current_pc[31:BTB_INDEX_BITS+2];
  assign pred_ctr     = pht[pred_pht_idx];
  assign pred_hit     = btb_valid[pred_btb_idx] && (btb_tag[pred_btb_idx] == pred_tag);

  assign bus.predict_taken = run && pred_ctr[COUNTER_BITS-1] && pred_hit;
  assign bus.predicted_pc  = bus.predict_taken ? btb_target[pred_btb_idx] : bus.current_pc + 32'd4;
  assign bus.ready         = run;

  assign upd_pht_idx = pht_index(bus.update_pc, ghr);
  assign upd_btb_idx = bus.update_pc[BTB_INDEX_BITS+1:2];
  assign upd_tag     = bus.update_pc[31:BTB_INDEX_BITS+2];
  assign upd_ctr_old = pht[upd_pht_idx];

  // Saturating counter step in the resolved direction
  always_comb begin
    upd_ctr_new = upd_ctr_old;
    if (bus.update_taken) begin
      if (upd_ctr_old != '1) upd_ctr_new = upd_ctr_old + COUNTER_BITS'(1);
    end else begin
      if (upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - COUNTER_BITS'(1);
    end
  end

  // Table storage: cleared by the INIT walk, trained by resolved branches in RUN
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      if ((init_idx >> PHT_INDEX_BITS) == '0) pht[init_idx[PHT_INDEX_BITS-1:0]] <= WEAK_NT;
      if ((init_idx >> BTB_INDEX_BITS) == '0) btb_valid[init_idx[BTB_INDEX_BITS-1:0]] <= 1'b0;
    end else if (bus.update_valid) begin
      pht[upd_pht_idx] <= upd_ctr_new;
      if (bus.update_taken) begin
        btb_valid[upd_btb_idx]  <= 1'b1;
        btb_tag[upd_btb_idx]    <= upd_tag;
        btb_target[upd_btb_idx] <= bus.update_target;
      end
    end
  end

  // Global history and saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr                <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else if (upd_fire) begin
      ghr <= {ghr[HIST_BITS-2:0], bus.update_taken};
      if (perf_branches_q != '1) perf_branches_q <= perf_branches_q + PERF_WIDTH'(1);
      if (bus.update_mispredict && (perf_mispredicts_q != '1))
        perf_mispredicts_q <= perf_mispredicts_q + PERF_WIDTH'(1);
    end
  end

  assign bus.perf_branches    = perf_branches_q;
  assign bus.perf_mispredicts = perf_mispredicts_q;

  // Byte-offset bits never participate in indexing or tagging
  assign unused_pc_bits = ^{bus.current_pc[1:0], bus.update_pc[1:0]};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor. Three instances share clock, reset
// and update payload: a bimodal one, a gshare one, and a bimodal one with
// 4-bit perf counters. A per-instance mask selects which one sees an update.
module tb_gshare_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] cur_pc;
  logic [2:0]  upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_misp;

  int vectors;
  int miscompares;

  gshare_btb_predictor_if                   ifc_b ();
  gshare_btb_predictor_if                   ifc_g ();
  gshare_btb_predictor_if #(.PERF_WIDTH(4)) ifc_p ();

  assign ifc_b.current_pc        = cur_pc;
  assign ifc_b.update_valid      = upd_valid[0];
  assign ifc_b.update_pc         = upd_pc;
  assign ifc_b.update_taken      = upd_taken;
  assign ifc_b.update_target     = upd_target;
  assign ifc_b.update_mispredict = upd_misp;

  assign ifc_g.current_pc        = cur_pc;
  assign ifc_g.update_valid      = upd_valid[1];
  assign ifc_g.update_pc         = upd_pc;
  assign ifc_g.update_taken      = upd_taken;
  assign ifc_g.update_target     = upd_target;
  assign ifc_g.update_mispredict = upd_misp;

  assign ifc_p.current_pc        = cur_pc;
  assign ifc_p.update_valid      = upd_valid[2];
  assign ifc_p.update_pc         = upd_pc;
  assign ifc_p.update_taken      = upd_taken;
  assign ifc_p.update_target     = upd_target;
  assign ifc_p.update_mispredict = upd_misp;

  gshare_btb_predictor #(.MODE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifc_b));
  gshare_btb_predictor #(.MODE(1'b1)) dut_g (.clk(clk), .rst(rst), .bus(ifc_g));
  gshare_btb_predictor #(.MODE(1'b0), .PERF_WIDTH(4)) dut_p (.clk(clk), .rst(rst), .bus(ifc_p));

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present an update on the falling edge and leave it pending for the next rising edge
  task automatic apply_update(input logic [2:0] mask, input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic misp);
    @(negedge clk);
    upd_valid  = mask;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    upd_misp   = misp;
    #1;
  endtask

  task automatic end_update();
    @(posedge clk);
    #1;
    upd_valid = 3'b000;
  endtask

  task automatic do_update(input logic [2:0] mask, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic misp);
    apply_update(mask, pc, taken, tgt, misp);
    end_update();
  endtask

  task automatic query(input logic [31:0] pc);
    cur_pc = pc;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    cur_pc      = 32'h100;
    upd_valid   = 3'b000;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;
    upd_misp    = 1'b0;

    // T1: reset state, INIT length, INIT pass-through, updates ignored in INIT
    #1;
    check_output("rst_ready", ifc_b.ready, 32'd0);
    check_output("rst_perf_br", ifc_b.perf_branches, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 3'b111; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80; upd_misp = 1'b1;
    #1;
    check_output("init_ready", ifc_b.ready, 32'd0);
    check_output("init_pred_pc", ifc_b.predicted_pc, 32'h104);
    check_output("init_pred_taken", ifc_b.predict_taken, 32'd0);
    repeat (63) @(posedge clk);
    #1;
    upd_valid = 3'b000;
    check_output("ready_63_b", ifc_b.ready, 32'd0);
    check_output("ready_63_g", ifc_g.ready, 32'd0);
    check_output("ready_63_p", ifc_p.ready, 32'd0);
    @(posedge clk);
    #1;
    check_output("ready_64_b", ifc_b.ready, 32'd1);
    check_output("ready_64_g", ifc_g.ready, 32'd1);
    check_output("ready_64_p", ifc_p.ready, 32'd1);
    check_output("init_perf_br", ifc_p.perf_branches, 32'd0);
    check_output("init_perf_misp", ifc_p.perf_mispredicts, 32'd0);
    check_output("run_untrained_pc", ifc_b.predicted_pc, 32'h104);

    // T2: bimodal train taken, then two not-taken
    do_update(3'b001, 32'h40, 1'b1, 32'h80, 1'b0);
    query(32'h40);
    check_output("t2_taken_pc", ifc_b.predicted_pc, 32'h80);
    check_output("t2_taken_flag", ifc_b.predict_taken, 32'd1);
    do_update(3'b001, 32'h40, 1'b0, 32'h0, 1'b0);
    do_update(3'b001, 32'h40, 1'b0, 32'h0, 1'b0);
    query(32'h40);
    check_output("t2_nt_pc", ifc_b.predicted_pc, 32'h44);
    check_output("t2_nt_flag", ifc_b.predict_taken, 32'd0);

    // T3: read-before-write on a same-cycle update, then tag alias
    do_update(3'b001, 32'h40, 1'b1, 32'h80, 1'b0);
    query(32'h40);
    check_output("t3_weak_pc", ifc_b.predicted_pc, 32'h44);
    apply_update(3'b001, 32'h40, 1'b1, 32'h80, 1'b0);
    check_output("t3_rbw_old", ifc_b.predicted_pc, 32'h44);
    end_update();
    check_output("t3_rbw_new", ifc_b.predicted_pc, 32'h80);
    query(32'h140);
    check_output("t3_alias_pc", ifc_b.predicted_pc, 32'h144);
    check_output("t3_alias_flag", ifc_b.predict_taken, 32'd0);

    // T4: counter saturates at 3, then walks back down
    for (int i = 0; i < 5; i++) do_update(3'b001, 32'h40, 1'b1, 32'h80, 1'b0);
    do_update(3'b001, 32'h40, 1'b0, 32'h0, 1'b0);
    query(32'h40);
    check_output("t4_sat_pc", ifc_b.predicted_pc, 32'h80);
    do_update(3'b001, 32'h40, 1'b0, 32'h0, 1'b0);
    do_update(3'b001, 32'h40, 1'b0, 32'h0, 1'b0);
    query(32'h40);
    check_output("t4_drain_pc", ifc_b.predicted_pc, 32'h44);

    // T5: gshare history changes the PHT index
    do_update(3'b010, 32'h40, 1'b1, 32'h80, 1'b0);
    query(32'h40);
    check_output("t5_ghr1_pc", ifc_g.predicted_pc, 32'h44);
    check_output("t5_ghr1_flag", ifc_g.predict_taken, 32'd0);
    query(32'h3C);
    check_output("t5_other_pc", ifc_g.predicted_pc, 32'h40);
    for (int i = 0; i < 6; i++) do_update(3'b010, 32'h204, 1'b0, 32'h0, 1'b0);
    query(32'h40);
    check_output("t5_ghr0_pc", ifc_g.predicted_pc, 32'h80);
    check_output("t5_ghr0_flag", ifc_g.predict_taken, 32'd1);

    // T6: 4-bit perf counters saturate, async reset clears them mid-cycle
    for (int i = 0; i < 20; i++) begin
      do_update(3'b100, 32'h40, i[0], 32'h80, (i >= 4));
      if (i == 9) begin
        check_output("t6_br_10", ifc_p.perf_branches, 32'd10);
        check_output("t6_misp_10", ifc_p.perf_mispredicts, 32'd6);
      end
    end
    check_output("t6_br_sat", ifc_p.perf_branches, 32'd15);
    check_output("t6_misp_sat", ifc_p.perf_mispredicts, 32'd15);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_rst_ready", ifc_p.ready, 32'd0);
    check_output("t6_rst_br", ifc_p.perf_branches, 32'd0);
    check_output("t6_rst_misp", ifc_p.perf_mispredicts, 32'd0);
    check_output("t6_rst_ready_g", ifc_g.ready, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    check_output("t6_reinit_ready", ifc_p.ready, 32'd1);
    query(32'h40);
    check_output("t6_reinit_g_pc", ifc_g.predicted_pc, 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
